// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - operand/product handshake bundle for alu_mul_seq
interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, mcand, mplier, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, mcand, mplier, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned shift-add multiplier driving an external ripple adder
// One partial product per clock; the adder sum/carry is shifted back into the accumulator.
module alu_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mul_seq_if.slave     bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     acc_hi, acc_lo, mc;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;
  logic                 in_ready;
  logic                 load;
  logic                 last;
  logic [2*WIDTH-1:0]   shifted;

  assign in_ready      = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign load          = in_ready & bus.in_valid;
  assign last          = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));
  // carry:sum:acc_lo shifted right by one, dropping the consumed multiplier bit
  assign shifted       = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

  assign add_a   = (state == CALC) ? acc_hi : '0;
  assign add_b   = ((state == CALC) && acc_lo[0]) ? mc : '0;
  assign add_cin = 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = load ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc_hi      <= '0;
      acc_lo      <= '0;
      mc          <= '0;
      cnt         <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mc     <= bus.mcand;
        acc_lo <= bus.mplier;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        {acc_hi, acc_lo} <= shifted;
        cnt              <= cnt + 1'b1;
      end
      if (last) begin
        product_q   <= shifted;
        out_valid_q <= 1'b1;
      end else if ((state == DONE) && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
